// File: rtl/index_decoder32.sv
// Index decoder: builds a 32-bit bitmap from set/clear/toggle index beats and emits it with a population count.
// Optional macro INDEX_MSB_FIRST_EN maps index i to bit 31-i instead of bit i.
module index_decoder32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_index,
  input  logic [1:0]  in_op,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] bitmap, bitmap_next, updated;
  logic [5:0]  count, count_next;
  logic [4:0]  pos;

`ifdef INDEX_MSB_FIRST_EN
  assign pos = 5'd31 - in_index;
`else
  assign pos = in_index;
`endif

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  always_comb begin
    updated = bitmap;
    case (in_op)
      2'b00:   updated[pos] = 1'b1;
      2'b01:   updated[pos] = 1'b0;
      2'b10:   updated[pos] = ~bitmap[pos];
      default: updated = bitmap;
    endcase

    state_next  = state;
    bitmap_next = bitmap;
    count_next  = count;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bitmap_next = updated;
          // Count is captured with the closing beat so it is stable throughout HOLD.
          if (in_last) begin
            state_next = HOLD;
            count_next = popcount(updated);
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next  = ACCUM;
          bitmap_next = '0;
          count_next  = '0;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ACCUM;
      bitmap <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      bitmap <= bitmap_next;
      count  <= count_next;
    end
  end

  assign out_data  = (state == HOLD) ? bitmap : '0;
  assign out_count = count;

endmodule

// File: tb/tb_index_decoder32.sv
// Self-checking bench for index_decoder32: vector table of bitmaps plus hand-written backpressure, reset and streaming sequences.
module tb_index_decoder32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_index;
  logic [1:0]  in_op;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_count;

  int tests = 0;
  int fails = 0;

  index_decoder32 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][4:0]  idx;
    logic [3:0][1:0]  op;
    logic [31:0]      data;
    logic [5:0]       cnt;
  } vec_t;

  vec_t tbl[6];

  // Expected bitmaps are written for index i -> bit i; MSB-first build mirrors them.
  function automatic logic [31:0] fix(input logic [31:0] x);
`ifdef INDEX_MSB_FIRST_EN
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = x[i];
    return r;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mk(input int k, input int n,
                    input int i0, input int o0, input int i1, input int o1,
                    input int i2, input int o2, input int i3, input int o3,
                    input logic [31:0] d, input int c);
    tbl[k].n      = 3'(n);
    tbl[k].idx[0] = 5'(i0); tbl[k].op[0] = 2'(o0);
    tbl[k].idx[1] = 5'(i1); tbl[k].op[1] = 2'(o1);
    tbl[k].idx[2] = 5'(i2); tbl[k].op[2] = 2'(o2);
    tbl[k].idx[3] = 5'(i3); tbl[k].op[3] = 2'(o3);
    tbl[k].data   = d;
    tbl[k].cnt    = 6'(c);
  endtask

  task automatic beat(input logic [4:0] idx, input logic [1:0] op, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_index = idx; in_op = op; in_last = last;
    chk("in_ready_accum", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data", out_data, 32'd0);
    chk("drain_out_count", 32'(out_count), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] d, input logic [5:0] c);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_data"}, out_data, d);
    chk({tag, "_out_count"}, 32'(out_count), 32'(c));
  endtask

  initial begin
    logic [31:0] q[$];
    int k, got;

    rst = 1'b1; in_valid = 1'b0; in_index = '0; in_op = '0; in_last = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    mk(0, 3, 0, 0, 5, 0, 31, 0, 0, 0, 32'h8000_0021, 3);
    mk(1, 4, 7, 0, 7, 2, 9, 2, 3, 3, 32'h0000_0200, 1);
    mk(2, 1, 10, 3, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);
    mk(3, 4, 3, 0, 3, 0, 3, 1, 8, 0, 32'h0000_0100, 1);
    mk(4, 4, 1, 2, 1, 2, 2, 0, 30, 1, 32'h0000_0004, 1);
    mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0001, 1);

    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < int'(tbl[v].n); j++) begin
        beat(tbl[v].idx[j], tbl[v].op[j], j == int'(tbl[v].n) - 1);
        if (j != int'(tbl[v].n) - 1) begin
          chk("accum_out_valid", 32'(out_valid), 32'd0);
          chk("accum_out_data", out_data, 32'd0);
        end
      end
      check_hold($sformatf("vec%0d", v), fix(tbl[v].data), tbl[v].cnt);
      drain();
    end

    // Full bitmap, then backpressure with a pending beat held by the producer.
    for (int i = 0; i < 32; i++) beat(5'(i), 2'b00, i == 31);
    @(negedge clk);
    in_valid = 1'b1; in_index = 5'd5; in_op = 2'b00; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_hold("full", 32'hFFFF_FFFF, 6'd32);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("full_release_in_ready", 32'(in_ready), 32'd1);
    chk("full_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("pending_out_data", out_data, fix(32'h0000_0020));
    chk("pending_out_count", 32'(out_count), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("pending_drained", 32'(out_valid), 32'd0);

    // Reset mid-accumulation, between clock edges.
    beat(5'd4, 2'b00, 1'b0);
    #2 rst = 1'b1; #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0;
    beat(5'd2, 2'b00, 1'b1);
    check_hold("after_midrst", fix(32'h0000_0004), 6'd1);
    drain();

    // Reset while holding a completed bitmap.
    beat(5'd9, 2'b00, 1'b1);
    #2 rst = 1'b1; #1;
    chk("holdrst_out_valid", 32'(out_valid), 32'd0);
    chk("holdrst_out_data", out_data, 32'd0);
    chk("holdrst_out_count", 32'(out_count), 32'd0);
    #1 rst = 1'b0;
    beat(5'd1, 2'b00, 1'b1);
    check_hold("after_holdrst", fix(32'h0000_0002), 6'd1);
    drain();

    // Streaming one-beat bitmaps with the consumer always ready.
    k = 0; got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      in_valid = (k < 8); in_index = 5'(k * 3); in_op = 2'b00; in_last = 1'b1; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        chk("stream_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          chk("stream_out_data", out_data, q[0]);
          chk("stream_out_count", 32'(out_count), 32'd1);
          void'(q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(fix(32'd1 << (k * 3)));
        k++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    chk("stream_emitted", 32'(got), 32'd8);
    chk("stream_accepted", 32'(k), 32'd8);
    chk("stream_leftover", 32'(q.size()), 32'd0);
    chk("stream_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
